// File: rtl/mat_stream_pack.sv
// mat_stream_pack: double-buffered serial-to-parallel packer turning a row-major
// element stream into the flat packed-matrix bus (element k at [k*DATA_WIDTH +: DATA_WIDTH]).
module mat_stream_pack #(
   parameter int DATA_WIDTH = 32,
   parameter int MATRIX_DIM = 4,
   localparam int MATRIX_SIZE = MATRIX_DIM * MATRIX_DIM
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [DATA_WIDTH-1:0]             s_data,
   input  logic                              s_last,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [MATRIX_SIZE*DATA_WIDTH-1:0] m_mat,
   output logic                              err
);
   localparam int IW = $clog2(MATRIX_SIZE);
   localparam int MW = MATRIX_SIZE * DATA_WIDTH;

   logic [MW-1:0] bank [2];
   logic [1:0]    full;
   logic          wr_bank, rd_bank;
   logic [IW-1:0] idx;
   logic          at_end, acc, rd;

   assign at_end  = idx == IW'(MATRIX_SIZE - 1);
   assign s_ready = !full[wr_bank];
   assign acc     = s_valid && s_ready;
   assign m_valid = full[rd_bank];
   assign m_mat   = bank[rd_bank];
   assign rd      = m_valid && m_ready;

   // a write only targets an empty bank and a read only a full one, so they never collide
   always_ff @(posedge clk) begin
      if (rst) begin
         idx     <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         bank[0] <= '0;
         bank[1] <= '0;
         err     <= 1'b0;
      end else begin
         err <= acc && (s_last != at_end);
         if (acc) begin
            bank[wr_bank][idx*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            idx <= (s_last || at_end) ? '0 : idx + 1'b1;
            if (s_last && at_end) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end
         end
         if (rd) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= !rd_bank;
         end
      end
   end
endmodule

// File: doc/mat_stream_pack.md
Name: mat_stream_pack

Overview:
- Serial-to-parallel matrix assembler on the producer side of the packed-matrix bus consumed by the determinant units.
- Accepts matrix elements one per cycle over a valid/ready stream, in row-major order.
- Packs them into the flat bus layout: element k at bits [k*DATA_WIDTH +: DATA_WIDTH], element 0 = a00.
- Double-buffered, so matrix N+1 loads while matrix N waits for the consumer.

Parameters:
- DATA_WIDTH, 32: element width in bits.
- MATRIX_DIM, 4: rows/columns of the square matrix; legal values 2..4.
- MATRIX_SIZE, MATRIX_DIM*MATRIX_DIM: element count. Derived; must not be overridden.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  block can accept an element.
- s_data  in  DATA_WIDTH  input element.
- s_last  in  1  marks final element of a matrix.
- m_valid  out  1  packed matrix available.
- m_ready  in  1  consumer accepts matrix.
- m_mat  out  MATRIX_SIZE*DATA_WIDTH  packed matrix, flat layout above.
- err  out  1  one-cycle pulse: framing error detected.

Behaviour:
- Reset (synchronous, active-high): element index=0, wr_bank=0, rd_bank=0, both bank full flags=0, both bank contents=0, m_valid=0, err=0, m_mat=0. s_ready=1 from the first cycle after rst deasserts. Reset mid-matrix discards all partial and full banks.
- Input handshake: element accepted when s_valid && s_ready on a rising edge.
  - Accepted s_data is written to bank[wr_bank] slot [index]; index then increments.
- s_ready = !full[wr_bank]. Combinational from registered flags only; no dependence on s_valid.
- Completion: an accepted element with index==MATRIX_SIZE-1 and s_last=1:
  - sets full[wr_bank], toggles wr_bank, resets index to 0;
  - m_valid rises the next cycle if that bank is the read bank (latency 1 cycle from last element to m_valid).
- Framing error: an accepted element with s_last=1 at index<MATRIX_SIZE-1, or s_last=0 at index==MATRIX_SIZE-1:
  - err pulses high for exactly one cycle (cycle after acceptance);
  - index resets to 0; the bank is not marked full and wr_bank is unchanged;
  - partial data is discarded (later overwritten); the next accepted element is element 0 of a new matrix.
- Output: m_valid = full[rd_bank]; m_mat = bank[rd_bank] contents.
  - While m_valid && !m_ready, m_mat and m_valid must hold stable.
  - On m_valid && m_ready: clear full[rd_bank], toggle rd_bank. m_valid may remain 1 next cycle if the other bank is already full (back-to-back matrices).
  - m_mat when m_valid=0 is don't-care but must not be X after reset.
- Simultaneous events:
  - Completing a write to one bank while the other is read in the same cycle: both take effect; no stall.
  - If both banks are full, s_ready=0. The consumer's handshake frees a bank and s_ready=1 the following cycle. No combinational m_ready->s_ready path.
- Throughput: sustained 1 element/cycle when the consumer accepts each matrix within MATRIX_SIZE cycles.
- Arithmetic: index counter is clog2(MATRIX_SIZE) bits and never exceeds MATRIX_SIZE-1. Data is stored unmodified (no sign/width changes).

Test Plan:
- MATRIX_DIM=2, DATA_WIDTH=8, stream 0x01,0x02,0x03,0x04 (last on 4th), m_ready=1:
  - m_mat=0x04030201;
  - m_valid high one cycle, asserted one cycle after the 4th acceptance.
- MATRIX_DIM=3, DATA_WIDTH=32, stream diag(2,3,4) row-major, then diag(1,1,1) back-to-back, m_ready=0 for 20 cycles:
  - first m_mat holds 2 at bits[31:0], 3 at [159:128], 4 at [287:256], rest 0; stable for all 20 cycles;
  - s_ready=0 after the second matrix completes;
  - raising m_ready delivers both matrices in order on consecutive cycles.
- MATRIX_DIM=4, s_last=1 on element index 5:
  - err pulses 1 cycle; no m_valid;
  - next 16 elements 0x10..0x1F form a correct matrix with 0x10 in slot 0.
- MATRIX_DIM=4, s_last=0 on element 15:
  - err pulse; no m_valid; index returns to 0.
- Assert rst after 7 elements of a matrix, with one full matrix pending:
  - next cycle m_valid=0, err=0, s_ready=1;
  - new 16-element matrix output is correct and contains no stale data.
- Random s_valid/m_ready throttling, 1000 matrices:
  - scoreboard matches every packed word in order;
  - no drops, duplicates or changes of m_mat while stalled.
